muldiv: RTL
===========

# muldiv

Iterative radix-2 multiply/divide unit sitting beside the execute stage. It serves RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Execute raises a start request with operands and signedness. This unit runs a fixed-latency shift-add or restoring-divide sequence and returns a 64-bit result with a one-cycle done pulse. Execute then picks the upper half (DIV*, MULH*) or the lower half (REM*, MUL).

## Interface
Parameters:
- None. Operand width is fixed at 32; the iteration count is fixed at 32.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  operation request (level); sampled only when idle.
- mul_or_div_i  in  1  `MUL or `DIV (from yadan_defs.v).
- dividend_i  in  32  operand 1 (multiplicand or dividend).
- divisor_i  in  32  operand 2 (multiplier or divisor).
- reg1_signed0_unsigned1_i  in  1  operand 1 signedness (`Signed or `Unsigned).
- reg2_signed0_unsigned1_i  in  1  operand 2 signedness.
- cancel_i  in  1  abort the current operation (interrupt or flush).
- result_o  out  64  MUL: full product. DIV: {quotient, remainder}.
- done_o  out  1  one-cycle completion pulse; result_o is valid while high.
- busy_o  out  1  an operation is in flight (state != IDLE).

## Operation
- States:
  - IDLE: wait for a request.
  - CALC: 32 iterations, 5-bit counter cnt.
  - FIX: sign correction and result write.
- IDLE -> CALC when start_i=1, done_o=0 and cancel_i=0.
  - Latch operands and op.
  - Capture sign flags: s1 = signed1 & dividend_i[31]; s2 = signed2 & divisor_i[31].
  - Load magnitudes: two's-complement negate each operand whose sign flag is set.
  - cnt <= 0.
- CALC, MUL: shift-add on the 64-bit accumulator, one multiplier bit per cycle.
- CALC, DIV: restoring divide, one quotient bit per cycle. Per step, trial-subtract the magnitude divisor from the partial remainder in 33-bit arithmetic.
- CALC -> FIX when cnt==31.
- FIX -> IDLE, registering corrected result_o and setting done_o<=1. Sign rules:
  - MUL: product = s1^s2 ? -P : P (64-bit negate).
  - DIV, divisor==0: quotient = 0xFFFFFFFF; remainder = original dividend_i (unsigned and signed alike, no sign fix).
  - DIV, otherwise: quotient negated if s1^s2; remainder negated if s1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF) falls out naturally: quotient 0x80000000, remainder 0. No special path is needed, but the case must be verified.
- Start qualification:
  - start_i is ignored while busy_o=1 (latched operands are not disturbed).
  - start_i is ignored in the cycle done_o=1, because execute still presents the old op that cycle.
- cancel_i:
  - In CALC or FIX: next state IDLE, no done pulse, result_o unchanged.
  - Same cycle as start_i in IDLE: cancel wins and nothing starts.
- done_o is cleared unconditionally on the cycle after it is set.

## Timing
- Reset values: state=IDLE, cnt=0, result_o=64'h0, done_o=0, busy_o=0, internal accumulators 0.
- Reset mid-operation aborts immediately; no done pulse.
- Latency, with start sampled at the end of cycle 0:
  - CALC occupies cycles 1–32.
  - FIX occupies cycle 33.
  - done_o=1 and result_o valid in cycle 34.
  - busy_o=1 in cycles 1–33, 0 in cycle 34.
- The latency is identical for every op, including divide-by-zero and overflow.
- result_o holds its value until the next FIX write or reset.
- Back-to-back: earliest next accept is the end of cycle 35, giving a throughput of one op per 35 cycles.
- busy_o and done_o are registered outputs; no combinational path from inputs to outputs.

## Test plan
- MUL unsigned, 0x00000007 × 0x00000006 -> done_o exactly in cycle 34, result_o=0x00000000_0000002A, busy_o high cycles 1–33.
- MUL signed×signed, 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF_FFFFFFFE. MULHSU (signed×unsigned), 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF_00000001.
- DIV signed, 0xFFFFFFF9 (−7) / 0x00000002 -> 0xFFFFFFFD_FFFFFFFF. DIVU 0x00000064 / 0x00000007 -> 0x0000000E_00000002.
- Boundaries:
  - DIVU 7/0 -> 0xFFFFFFFF_00000007.
  - DIV signed 0xFFFFFFF9/0 -> 0xFFFFFFFF_FFFFFFF9.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000_00000000.
- Abort paths:
  - cancel_i in cycle 10 -> no done_o, busy_o=0 from cycle 11, result_o unchanged.
  - A new start in cycle 11 completes normally in cycle 45.
  - rst asserted in cycle 20 -> all outputs at reset values next cycle.
- Start held high through completion:
  - The done cycle does not re-accept start.
  - Changing operands mid-CALC does not alter the result.
  - A second op accepted at cycle 35 completes at cycle 69.

Source files
------------

// File: rtl/muldiv.sv
// ============================================================================
// Module   : muldiv
// Purpose  : Iterative radix-2 multiply/divide unit for RV32M. Shift-add
//            multiply or restoring divide over 32 steps, then sign fix-up.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        mul_or_div_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        reg1_signed0_unsigned1_i,
    input  logic        reg2_signed0_unsigned1_i,
    input  logic        cancel_i,
    output logic [63:0] result_o,
    output logic        done_o,
    output logic        busy_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CALC   = 2'd1;
    localparam logic [1:0] c_FIX    = 2'd2;
    localparam logic       c_OP_DIV = 1'b1;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [31:0] r_dividend_orig;
    logic        r_op;
    logic        r_s1;
    logic        r_s2;
    logic        r_div_zero;
    logic [63:0] r_result;
    logic        r_done;

    // Operand sign flags and magnitudes captured at accept time
    logic        w_s1;
    logic        w_s2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_accept;

    assign w_s1     = ~reg1_signed0_unsigned1_i & dividend_i[31];
    assign w_s2     = ~reg2_signed0_unsigned1_i & divisor_i[31];
    assign w_mag1   = w_s1 ? (32'd0 - dividend_i) : dividend_i;
    assign w_mag2   = w_s2 ? (32'd0 - divisor_i) : divisor_i;
    assign w_accept = start_i & ~r_done & ~cancel_i;

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift the whole thing right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide step: acc = {remainder, dividend bits / quotient bits}
    logic [32:0] w_part;
    logic [32:0] w_trial;
    logic        w_qbit;
    logic [63:0] w_div_next;

    assign w_part     = r_acc[63:31];
    assign w_trial    = w_part - {1'b0, r_opnd};
    assign w_qbit     = ~w_trial[32];
    assign w_div_next = {(w_qbit ? w_trial[31:0] : w_part[31:0]), r_acc[30:0], w_qbit};

    // Sign correction applied in FIX
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [63:0] w_div_fix;
    logic [63:0] w_final;

    assign w_prod_fix = (r_s1 ^ r_s2) ? (64'd0 - r_acc) : r_acc;
    assign w_quot_fix = (r_s1 ^ r_s2) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem_fix  = r_s1 ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_div_fix  = r_div_zero ? {32'hFFFF_FFFF, r_dividend_orig}
                                   : {w_quot_fix, w_rem_fix};
    assign w_final    = (r_op == c_OP_DIV) ? w_div_fix : w_prod_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_cnt           <= 5'd0;
            r_acc           <= 64'd0;
            r_opnd          <= 32'd0;
            r_dividend_orig <= 32'd0;
            r_op            <= 1'b0;
            r_s1            <= 1'b0;
            r_s2            <= 1'b0;
            r_div_zero      <= 1'b0;
            r_result        <= 64'd0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state         <= c_CALC;
                        r_cnt           <= 5'd0;
                        r_op            <= mul_or_div_i;
                        r_s1            <= w_s1;
                        r_s2            <= w_s2;
                        r_dividend_orig <= dividend_i;
                        r_div_zero      <= (divisor_i == 32'd0);
                        r_opnd          <= (mul_or_div_i == c_OP_DIV) ? w_mag2 : w_mag1;
                        r_acc           <= {32'd0, (mul_or_div_i == c_OP_DIV) ? w_mag1 : w_mag2};
                    end
                end
                c_CALC: begin
                    if (cancel_i) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= (r_op == c_OP_DIV) ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= c_FIX;
                        end
                    end
                end
                c_FIX: begin
                    r_state <= c_IDLE;
                    if (!cancel_i) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign result_o = r_result;
    assign done_o   = r_done;
    assign busy_o   = (r_state != c_IDLE);

endmodule

`default_nettype wire
